// File: rtl/pc_register.sv
// pc_register: program counter for the fetch stage.
// Holds the address of the next instruction word. On each rising clock edge
// the counter either loads a branch/jump target, advances by INC_STEP, or
// holds. Priority is load over increment over hold. An active-low
// asynchronous reset clears the counter. data_out is driven straight from
// the register, so no input reaches it combinationally except reset.
module pc_register #(
  parameter int unsigned           WIDTH       = 16,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]      INC_STEP    = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic             inc,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  // Choose the next counter value: load wins over increment, otherwise hold.
  // The sum is WIDTH bits wide, so the carry out is dropped and 0xFFFF + 1
  // wraps to 0x0000.
  always_comb begin
    count_next = count;
    if (load_enable) begin
      count_next = data_in;
    end else if (inc) begin
      count_next = count + INC_STEP;
    end
  end

  // Counter register. Reset is checked first and asynchronously, so X on the
  // other inputs cannot reach the counter while reset is held low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RESET_VALUE;
    end else begin
      count <= count_next;
    end
  end

  assign data_out = count;

endmodule

// File: tb/tb_pc_register.sv
// tb_pc_register: self-checking bench for pc_register.
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the counter kept in the bench.
module tb_pc_register;

  logic        clk;
  logic        reset;
  logic        load_enable;
  logic        inc;
  logic [15:0] data_in;
  logic [15:0] data_out;

  int compare_count;
  int fail_count;
  int model_pc;

  pc_register #(
    .WIDTH      (16),
    .RESET_VALUE(16'h0000),
    .INC_STEP   (16'h0001)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_enable(load_enable),
    .inc        (inc),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when it does not match.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive inputs, take one rising edge, update the model and check 1 after it.
  task automatic applyStimulus(input string tag, input logic le, input logic in_inc,
                               input logic [15:0] din);
    load_enable = le;
    inc         = in_inc;
    data_in     = din;
    @(posedge clk);
    if (reset !== 1'b1)      model_pc = 0;
    else if (le)             model_pc = din;
    else if (in_inc)         model_pc = (model_pc + 1) % 65536;
    #1;
    checkOutput(tag, data_out, 16'(model_pc));
  endtask

  initial begin
    compare_count = 0;
    fail_count    = 0;
    model_pc      = 0;

    // Reset held low from time zero with increments requested.
    reset       = 1'b0;
    load_enable = 1'b0;
    inc         = 1'b1;
    data_in     = 16'h0000;
    #1;
    checkOutput("reset_async", data_out, 16'h0000);
    for (int i = 0; i < 5; i++) applyStimulus("reset_hold_inc", 1'b0, 1'b1, 16'h0000);
    applyStimulus("reset_hold_idle", 1'b0, 1'b0, 16'h0000);
    applyStimulus("reset_hold_x", 1'bx, 1'bx, 16'hxxxx);
    checkOutput("reset_x_blocked", data_out, 16'h0000);

    // Release away from the clock edge, idle, then count up.
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus("idle_after_release", 1'b0, 1'b0, 16'hABCD);
    checkOutput("idle_value", data_out, 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus("inc_run", 1'b0, 1'b1, 16'h0000);
      checkOutput("inc_run_const", data_out, 16'(i));
    end

    // Load beats increment, then increment from the loaded value.
    applyStimulus("load_priority", 1'b1, 1'b1, 16'h1234);
    checkOutput("load_priority_const", data_out, 16'h1234);
    applyStimulus("inc_after_load", 1'b0, 1'b1, 16'h0000);
    checkOutput("inc_after_load_const", data_out, 16'h1235);

    // Wrap at the top of the range.
    applyStimulus("load_ffff", 1'b1, 1'b0, 16'hFFFF);
    applyStimulus("wrap", 1'b0, 1'b1, 16'h0000);
    checkOutput("wrap_const", data_out, 16'h0000);

    // Reset asserted between edges during an increment run.
    applyStimulus("load_0100", 1'b1, 1'b0, 16'h0100);
    applyStimulus("inc_0101", 1'b0, 1'b1, 16'h0000);
    checkOutput("inc_0101_const", data_out, 16'h0101);
    #2;
    reset    = 1'b0;
    model_pc = 0;
    #1;
    checkOutput("mid_reset_async", data_out, 16'h0000);
    applyStimulus("mid_reset_hold_inc", 1'b0, 1'b1, 16'h0000);
    applyStimulus("mid_reset_hold_load", 1'b1, 1'b1, 16'h5555);
    reset = 1'b1;
    applyStimulus("post_reset_inc", 1'b0, 1'b1, 16'h0000);
    checkOutput("post_reset_inc_const", data_out, 16'h0001);

    // Randomized mix of load, increment and hold, biased toward increments
    // and occasionally loading near the wrap point.
    for (int i = 0; i < 60; i++) begin
      logic        le;
      logic        in_inc;
      logic [15:0] din;
      le     = ($urandom_range(0, 3) == 0);
      in_inc = ($urandom_range(0, 2) != 0);
      din    = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2))
                                           : 16'($urandom);
      applyStimulus("random", le, in_inc, din);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
